// File: rtl/aipp_pkg.sv
// Shared types and helpers for the AIPP trigger engine: FSM state encoding,
// the default heavy-load opcode and the event-id width rule.
package aipp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } aipp_state_e;

    localparam logic [15:0] AIPP_OPC_HEAVY = 16'hBEFF;

    // A single-entry table still needs a 1-bit id so the port never collapses to zero width.
    function automatic int aipp_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aipp_trigger_engine_if.sv
// Ingress, configuration and event-record bundle between the trigger engine and its
// environment; slave is the engine side, master the driving side.
interface aipp_trigger_engine_if
    import aipp_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int OPC_W   = 16,
    parameter int NUM_OPC = 4,
    parameter int CNT_W   = 8
) ();
    localparam int ID_W = aipp_id_w(NUM_OPC);

    logic [DATA_W-1:0]        pkt_data;
    logic                     pkt_valid;
    logic [NUM_OPC*OPC_W-1:0] cfg_opcode;
    logic [NUM_OPC-1:0]       cfg_opc_en;
    logic [CNT_W-1:0]         cfg_holdoff;
    logic                     gpop_trigger;
    logic                     trig_valid;
    logic                     trig_ready;
    logic [ID_W-1:0]          trig_id;
    logic [CNT_W-1:0]         match_count;
    logic [15:0]              evt_count;
    logic [7:0]               drop_count;

    modport master (
        output pkt_data, pkt_valid, cfg_opcode, cfg_opc_en, cfg_holdoff, trig_ready,
        input  gpop_trigger, trig_valid, trig_id, match_count, evt_count, drop_count
    );

    modport slave (
        input  pkt_data, pkt_valid, cfg_opcode, cfg_opc_en, cfg_holdoff, trig_ready,
        output gpop_trigger, trig_valid, trig_id, match_count, evt_count, drop_count
    );

endinterface

// File: rtl/aipp_opcode_cam.sv
// Combinational opcode table lookup: compares the beat's opcode field against every
// enabled entry and reports the lowest matching index.
module aipp_opcode_cam
    import aipp_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int OPC_W   = 16,
    parameter int OPC_LSB = 0,
    parameter int NUM_OPC = 4,
    parameter int ID_W    = aipp_id_w(NUM_OPC)
) (
    input  logic [DATA_W-1:0]        i_pkt_data,
    input  logic                     i_pkt_valid,
    input  logic [NUM_OPC*OPC_W-1:0] i_cfg_opcode,
    input  logic [NUM_OPC-1:0]       i_cfg_opc_en,
    output logic                     o_hit,
    output logic [ID_W-1:0]          o_hit_id
);

    logic [OPC_W-1:0]   w_field;
    logic [NUM_OPC-1:0] w_eq;
    logic               w_unused_data;

    assign w_field       = i_pkt_data[OPC_LSB +: OPC_W];
    assign w_unused_data = ^i_pkt_data;

    generate
        for (genvar gi = 0; gi < NUM_OPC; gi++) begin : g_cmp
            assign w_eq[gi] = i_pkt_valid && i_cfg_opc_en[gi] &&
                              (w_field == i_cfg_opcode[gi*OPC_W +: OPC_W]);
        end
    endgenerate

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        o_hit    = 1'b0;
        o_hit_id = '0;
        for (int i = NUM_OPC - 1; i >= 0; i--) begin
            if (w_eq[i]) begin
                o_hit    = 1'b1;
                o_hit_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/aipp_trigger_engine.sv
// Multi-opcode line-rate trigger: debounces consecutive opcode matches, fires a stretched
// pulse plus a handshaked event record, then holds off before re-arming.
module aipp_trigger_engine
    import aipp_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int OPC_W      = 16,
    parameter int OPC_LSB    = 0,
    parameter int NUM_OPC    = 4,
    parameter int DEBOUNCE   = 8,
    parameter int PULSE_LEN  = 16,
    parameter int CNT_W      = 8,
    parameter int STRICT_VLD = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aipp_trigger_engine_if.slave  bus
);

    localparam int ID_W   = aipp_id_w(NUM_OPC);
    localparam int PCNT_W = $clog2(PULSE_LEN + 1);
    localparam int TMR_W  = (CNT_W > PCNT_W) ? CNT_W : PCNT_W;
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] DEB        = CNT_W'(DEBOUNCE);

    aipp_state_e      r_state, r_state_next;
    logic [TMR_W-1:0] r_tmr, r_tmr_next;
    logic [CNT_W-1:0] r_match, r_match_next;
    logic [ID_W-1:0]  r_id, r_id_next;
    logic             r_gpop, r_gpop_next;
    logic             r_tv, r_tv_next;
    logic [ID_W-1:0]  r_tid, r_tid_next;
    logic [15:0]      r_evt, r_evt_next;
    logic [7:0]       r_drop, r_drop_next;
    logic             w_hit, w_fire;
    logic [ID_W-1:0]  w_hit_id;

    aipp_opcode_cam #(
        .DATA_W(DATA_W), .OPC_W(OPC_W), .OPC_LSB(OPC_LSB), .NUM_OPC(NUM_OPC), .ID_W(ID_W)
    ) u_cam (
        .i_pkt_data(bus.pkt_data), .i_pkt_valid(bus.pkt_valid),
        .i_cfg_opcode(bus.cfg_opcode), .i_cfg_opc_en(bus.cfg_opc_en),
        .o_hit(w_hit), .o_hit_id(w_hit_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_match <= '0;
            r_id    <= '0;
            r_gpop  <= 1'b0;
            r_tv    <= 1'b0;
            r_tid   <= '0;
            r_evt   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= r_state_next;
            r_tmr   <= r_tmr_next;
            r_match <= r_match_next;
            r_id    <= r_id_next;
            r_gpop  <= r_gpop_next;
            r_tv    <= r_tv_next;
            r_tid   <= r_tid_next;
            r_evt   <= r_evt_next;
            r_drop  <= r_drop_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        r_tmr_next   = r_tmr;
        r_match_next = r_match;
        r_id_next    = r_id;
        r_gpop_next  = r_gpop;
        r_tv_next    = r_tv;
        r_tid_next   = r_tid;
        r_evt_next   = r_evt;
        r_drop_next  = r_drop;
        w_fire       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    r_id_next = w_hit_id;
                    if (DEBOUNCE == 1) begin
                        w_fire = 1'b1;
                    end else begin
                        r_state_next = ST_ARMING;
                        r_match_next = CNT_W'(1);
                    end
                end
            end
            ST_ARMING: begin
                if (w_hit) begin
                    if (w_hit_id != r_id) begin
                        r_id_next    = w_hit_id;
                        r_match_next = CNT_W'(1);
                    end else if (r_match + CNT_W'(1) == DEB) begin
                        w_fire = 1'b1;
                    end else begin
                        r_match_next = r_match + CNT_W'(1);
                    end
                end else if (bus.pkt_valid || (STRICT_VLD != 0)) begin
                    r_state_next = ST_IDLE;
                    r_match_next = '0;
                end
            end
            ST_FIRE: begin
                if (r_tmr == '0) begin
                    r_gpop_next = 1'b0;
                    if (bus.cfg_holdoff == '0) begin
                        r_state_next = ST_IDLE;
                    end else begin
                        r_state_next = ST_HOLDOFF;
                        r_tmr_next   = TMR_W'(bus.cfg_holdoff) - TMR_W'(1);
                    end
                end else begin
                    r_tmr_next = r_tmr - TMR_W'(1);
                end
            end
            default: begin
                if (r_tmr == '0) r_state_next = ST_IDLE;
                else             r_tmr_next   = r_tmr - TMR_W'(1);
            end
        endcase

        // A fresh fire may only overwrite the record slot if it is empty or draining this cycle.
        if (w_fire) begin
            r_state_next = ST_FIRE;
            r_match_next = '0;
            r_tmr_next   = PULSE_LOAD;
            r_gpop_next  = 1'b1;
            r_evt_next   = r_evt + 16'd1;
            if (!r_tv || bus.trig_ready) begin
                r_tv_next  = 1'b1;
                r_tid_next = w_hit_id;
            end else if (r_drop != 8'hFF) begin
                r_drop_next = r_drop + 8'd1;
            end
        end else if (r_tv && bus.trig_ready) begin
            r_tv_next = 1'b0;
        end
    end

    assign bus.gpop_trigger = r_gpop;
    assign bus.trig_valid   = r_tv;
    assign bus.trig_id      = r_tid;
    assign bus.match_count  = r_match;
    assign bus.evt_count    = r_evt;
    assign bus.drop_count   = r_drop;

endmodule

// File: tb/tb_aipp_trigger_engine.sv
// Bench for aipp_trigger_engine: a strict and a lenient instance share stimulus and are
// compared every cycle against a timeline-based reference, plus directed literal checks.
module tb_aipp_trigger_engine;
    import aipp_pkg::*;

    localparam int DATA_W = 64, OPC_W = 16, NUM_OPC = 4, CNT_W = 8;
    localparam int DEB = 8, PLEN = 16;
    localparam logic [15:0] OPC_CAFE  = 16'hCAFE;
    localparam logic [15:0] OPC_FLUSH = 16'h5A5A;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [DATA_W-1:0]        pkt_data;
    logic                     pkt_valid;
    logic [NUM_OPC*OPC_W-1:0] cfg_opcode;
    logic [NUM_OPC-1:0]       cfg_opc_en;
    logic [CNT_W-1:0]         cfg_holdoff;
    logic                     trig_ready;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;

    always #5 clk = ~clk;

    aipp_trigger_engine_if #(.DATA_W(DATA_W), .OPC_W(OPC_W), .NUM_OPC(NUM_OPC), .CNT_W(CNT_W)) bus_s ();
    aipp_trigger_engine_if #(.DATA_W(DATA_W), .OPC_W(OPC_W), .NUM_OPC(NUM_OPC), .CNT_W(CNT_W)) bus_l ();

    assign bus_s.pkt_data = pkt_data;      assign bus_l.pkt_data = pkt_data;
    assign bus_s.pkt_valid = pkt_valid;    assign bus_l.pkt_valid = pkt_valid;
    assign bus_s.cfg_opcode = cfg_opcode;  assign bus_l.cfg_opcode = cfg_opcode;
    assign bus_s.cfg_opc_en = cfg_opc_en;  assign bus_l.cfg_opc_en = cfg_opc_en;
    assign bus_s.cfg_holdoff = cfg_holdoff; assign bus_l.cfg_holdoff = cfg_holdoff;
    assign bus_s.trig_ready = trig_ready;  assign bus_l.trig_ready = trig_ready;

    aipp_trigger_engine #(.DATA_W(DATA_W), .OPC_W(OPC_W), .OPC_LSB(0), .NUM_OPC(NUM_OPC),
        .DEBOUNCE(DEB), .PULSE_LEN(PLEN), .CNT_W(CNT_W), .STRICT_VLD(1))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    aipp_trigger_engine #(.DATA_W(DATA_W), .OPC_W(OPC_W), .OPC_LSB(0), .NUM_OPC(NUM_OPC),
        .DEBOUNCE(DEB), .PULSE_LEN(PLEN), .CNT_W(CNT_W), .STRICT_VLD(0))
        dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference: index 0 = strict instance, 1 = lenient ----------------
    longint cyc = 0;
    int     m_run_len[2], m_run_id[2], m_evt[2], m_drop[2], m_tid[2];
    longint m_fire_edge[2], m_resume[2];
    bit     m_tv[2];

    function automatic int lookup();
        for (int i = 0; i < NUM_OPC; i++)
            if (pkt_valid && cfg_opc_en[i] && pkt_data[15:0] == cfg_opcode[i*OPC_W +: OPC_W])
                return i;
        return -1;
    endfunction

    task automatic model_reset(input int k);
        m_run_len[k] = 0; m_run_id[k] = 0; m_evt[k] = 0; m_drop[k] = 0; m_tid[k] = 0;
        m_tv[k] = 1'b0; m_fire_edge[k] = -1000000; m_resume[k] = 0;
    endtask

    // Timeline view: beats count only from m_resume on; a fire blocks evaluation until
    // PULSE_LEN + holdoff edges have passed.
    task automatic model_step(input int k);
        int  hit;
        bit  fire;
        hit  = lookup();
        fire = 1'b0;
        if (cyc == m_fire_edge[k] + PLEN)
            m_resume[k] = cyc + longint'(cfg_holdoff) + 1;
        if (cyc >= m_resume[k]) begin
            if (hit >= 0) begin
                if (m_run_len[k] > 0 && hit == m_run_id[k]) m_run_len[k]++;
                else begin m_run_id[k] = hit; m_run_len[k] = 1; end
                if (m_run_len[k] == DEB) begin fire = 1'b1; m_run_len[k] = 0; end
            end else if (pkt_valid || k == 0) begin
                m_run_len[k] = 0;
            end
        end
        if (fire) begin
            m_fire_edge[k] = cyc;
            m_resume[k]    = 64'h7FFF_FFFF_FFFF;
            m_evt[k]       = (m_evt[k] + 1) & 16'hFFFF;
            if (!m_tv[k] || trig_ready) begin m_tv[k] = 1'b1; m_tid[k] = hit; end
            else if (m_drop[k] < 255) m_drop[k]++;
        end else if (m_tv[k] && trig_ready) begin
            m_tv[k] = 1'b0;
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            cyc++;
            model_step(0);
            model_step(1);
        end
        #1;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit exp_g;
                exp_g = (cyc >= m_fire_edge[k]) && (cyc < m_fire_edge[k] + PLEN) && rst_n;
                if (k == 0) begin
                    chk("s_gpop", bus_s.gpop_trigger, exp_g);
                    chk("s_tvalid", bus_s.trig_valid, m_tv[0]);
                    chk("s_tid", bus_s.trig_id, m_tid[0]);
                    chk("s_match", bus_s.match_count, m_run_len[0]);
                    chk("s_evt", bus_s.evt_count, m_evt[0]);
                    chk("s_drop", bus_s.drop_count, m_drop[0]);
                end else begin
                    chk("l_gpop", bus_l.gpop_trigger, exp_g);
                    chk("l_tvalid", bus_l.trig_valid, m_tv[1]);
                    chk("l_tid", bus_l.trig_id, m_tid[1]);
                    chk("l_match", bus_l.match_count, m_run_len[1]);
                    chk("l_evt", bus_l.evt_count, m_evt[1]);
                    chk("l_drop", bus_l.drop_count, m_drop[1]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [15:0] opc, input logic vld);
        @(negedge clk);
        pkt_data  = {$urandom(), 16'($urandom()), opc};
        pkt_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) beat(OPC_FLUSH, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pkt_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  npulse, rise0, rise1, evt_s0, evt_l0, burst;
        bit  prev_g;
        rst_n = 1'b0;
        pkt_data = '0; pkt_valid = 1'b0; trig_ready = 1'b1; cfg_holdoff = '0;
        cfg_opcode = '0; cfg_opcode[15:0] = AIPP_OPC_HEAVY; cfg_opc_en = 4'b0001;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_gpop", bus_s.gpop_trigger, 0);
        chk("reset_evt", bus_l.evt_count, 0);
        @(negedge clk); rst_n = 1'b1;

        // 1: eight heavy beats -> 16-cycle pulse, id 0
        for (int i = 0; i < DEB; i++) beat(AIPP_OPC_HEAVY, 1'b1);
        chk("t1_gpop_rise", bus_s.gpop_trigger, 1);
        chk("t1_tid", bus_s.trig_id, 0);
        chk("t1_evt", bus_s.evt_count, 1);
        npulse = 1;
        for (int i = 0; i < 100; i++) begin
            beat(OPC_FLUSH, 1'b1);
            if (bus_s.gpop_trigger) npulse++; else break;
        end
        chk("t1_pulse_len", npulse, PLEN);
        flush(4);

        // 2: invalid beat mid-run aborts only the strict instance
        evt_s0 = bus_s.evt_count; evt_l0 = bus_l.evt_count;
        for (int i = 0; i < 5; i++) beat(AIPP_OPC_HEAVY, 1'b1);
        beat(AIPP_OPC_HEAVY, 1'b0);
        for (int i = 0; i < 3; i++) beat(AIPP_OPC_HEAVY, 1'b1);
        chk("t2_strict_nofire", bus_s.evt_count, evt_s0);
        chk("t2_strict_cnt", bus_s.match_count, 3);
        chk("t2_lax_fire", bus_l.evt_count, evt_l0 + 1);
        flush(PLEN + 4);

        // 3: opcode switch restarts the count; second entry reports id 1
        cfg_opcode[31:16] = OPC_CAFE; cfg_opc_en = 4'b0011;
        for (int i = 0; i < 4; i++) beat(AIPP_OPC_HEAVY, 1'b1);
        chk("t3_cnt4", bus_s.match_count, 4);
        beat(OPC_CAFE, 1'b1);
        chk("t3_restart", bus_s.match_count, 1);
        for (int i = 1; i < DEB; i++) beat(OPC_CAFE, 1'b1);
        chk("t3_tid1", bus_s.trig_id, 1);
        chk("t3_gpop", bus_s.gpop_trigger, 1);
        flush(PLEN + 4);
        evt_s0 = bus_s.evt_count;
        for (int i = 0; i < DEB - 1; i++) beat(OPC_CAFE, 1'b1);
        flush(2);
        chk("t3_seven_nofire", bus_s.evt_count, evt_s0);

        // 4: back-pressure drops the second record and keeps the first
        do_reset();
        trig_ready = 1'b0; cfg_holdoff = '0;
        for (int i = 0; i < DEB; i++) beat(AIPP_OPC_HEAVY, 1'b1);
        flush(PLEN + 2);
        for (int i = 0; i < DEB; i++) beat(OPC_CAFE, 1'b1);
        chk("t4_drop", bus_s.drop_count, 1);
        chk("t4_held_id", bus_s.trig_id, 0);
        chk("t4_evt", bus_s.evt_count, 2);
        @(negedge clk); trig_ready = 1'b1;
        beat(OPC_FLUSH, 1'b1);
        chk("t4_accepted", bus_s.trig_valid, 0);
        flush(PLEN + 2);

        // 5: holdoff 10 with a continuous stream -> pulses 16+10+8 edges apart
        do_reset();
        cfg_holdoff = 8'd10;
        rise0 = -1; rise1 = -1; prev_g = 1'b0;
        for (int i = 0; i < 90; i++) begin
            beat(AIPP_OPC_HEAVY, 1'b1);
            if (bus_s.gpop_trigger && !prev_g) begin
                if (rise0 < 0) rise0 = i; else if (rise1 < 0) rise1 = i;
            end
            prev_g = bus_s.gpop_trigger;
        end
        chk("t5_found_two", (rise0 >= 0 && rise1 >= 0), 1);
        chk("t5_gap", rise1 - rise0, PLEN + 10 + DEB);
        flush(PLEN + 12);

        // 6: asynchronous reset in the middle of a pulse
        cfg_holdoff = '0;
        for (int i = 0; i < DEB + 5; i++) beat(AIPP_OPC_HEAVY, 1'b1);
        chk("t6_pre_gpop", bus_s.gpop_trigger, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_gpop", bus_s.gpop_trigger, 0);
        chk("t6_async_tv", bus_l.trig_valid, 0);
        chk("t6_async_evt", bus_s.evt_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEB; i++) beat(AIPP_OPC_HEAVY, 1'b1);
        chk("t6_rearm", bus_s.evt_count, 1);
        flush(PLEN + 2);

        // random phase: live table changes, bursty opcodes, random valid/ready
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                @(negedge clk);
                for (int e = 0; e < NUM_OPC; e++) begin
                    case ($urandom_range(3))
                        0: cfg_opcode[e*OPC_W +: OPC_W] = AIPP_OPC_HEAVY;
                        1: cfg_opcode[e*OPC_W +: OPC_W] = OPC_CAFE;
                        2: cfg_opcode[e*OPC_W +: OPC_W] = 16'h0F0F;
                        default: cfg_opcode[e*OPC_W +: OPC_W] = 16'h7777;
                    endcase
                end
                cfg_opc_en  = 4'($urandom());
                cfg_holdoff = 8'($urandom_range(5));
            end
            if ($urandom_range(11) == 0) burst = $urandom_range(3);
            trig_ready = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0)
                beat(16'($urandom()), ($urandom_range(9) != 0));
            else
                beat(cfg_opcode[burst*OPC_W +: OPC_W], ($urandom_range(15) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
